// File: rtl/otter_ctrl_pkg.sv
// Shared types for the OTTER control-flow redirect logic: PC mux encodings
// and the interrupt-entry sequencer states.
package otter_ctrl_pkg;

  typedef enum logic [2:0] {
    PC_PLUS4  = 3'd0,
    PC_JALR   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JAL    = 3'd3,
    PC_MTVEC  = 3'd4,
    PC_MEPC   = 3'd5
  } pc_sel_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    TRAP  = 2'd2
  } redir_state_t;

endpackage

// File: rtl/otter_redirect_ctrl.sv
// Redirect sequencer for the OTTER pipeline: turns the EX branch/jump/MRET
// decision into PC-mux and flush controls and walks interrupt entry through drain and trap.
module otter_redirect_ctrl
  import otter_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int XLEN         = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            STALL,
  input  logic            EX_VALID,
  input  logic [2:0]      EX_PC_SOURCE,
  input  logic            EX_IS_MRET,
  input  logic [XLEN-1:0] EX_PC,
  input  logic            INTR,
  input  logic            MIE,
  output logic [2:0]      PC_SEL,
  output logic            HOLD_PC,
  output logic            FLUSH_IF_ID,
  output logic            FLUSH_ID_EX,
  output logic            SQUASH_EX,
  output logic            INT_TAKEN,
  output logic            MEPC_WE,
  output logic [XLEN-1:0] MEPC,
  output logic            BUSY
);

  localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  redir_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] mepc_q, mepc_d;

  pc_sel_t ex_src;
  logic    redirect;
  logic    accept;
  pc_sel_t pc_sel;

  // Codes 4-7 never legitimately come from EX; fall back to sequential fetch.
  assign ex_src   = EX_PC_SOURCE[2] ? PC_PLUS4 : pc_sel_t'(EX_PC_SOURCE);
  assign redirect = EX_VALID && (EX_IS_MRET || (ex_src != PC_PLUS4));
  assign accept   = EX_VALID && INTR && MIE && !redirect;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      cnt_q   <= '0;
      mepc_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mepc_q  <= mepc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mepc_d  = mepc_q;
    if (!STALL) begin
      unique case (state_q)
        RUN: begin
          if (accept) begin
            mepc_d = EX_PC;
            if (DRAIN_CYCLES == 0) begin
              state_d = TRAP;
            end else begin
              state_d = DRAIN;
              cnt_d   = CNT_INIT;
            end
          end
        end
        DRAIN: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_LAST) state_d = TRAP;
        end
        TRAP:    state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    pc_sel      = PC_PLUS4;
    HOLD_PC     = 1'b0;
    FLUSH_IF_ID = 1'b0;
    FLUSH_ID_EX = 1'b0;
    SQUASH_EX   = 1'b0;
    INT_TAKEN   = 1'b0;
    MEPC_WE     = 1'b0;
    BUSY        = 1'b0;
    if (!RST) begin
      unique case (state_q)
        RUN: begin
          if (!STALL) begin
            if (EX_VALID && EX_IS_MRET) begin
              pc_sel      = PC_MEPC;
              FLUSH_IF_ID = 1'b1;
              FLUSH_ID_EX = 1'b1;
            end else if (redirect) begin
              pc_sel      = ex_src;
              FLUSH_IF_ID = 1'b1;
              FLUSH_ID_EX = 1'b1;
            end else if (accept) begin
              HOLD_PC     = 1'b1;
              FLUSH_IF_ID = 1'b1;
              FLUSH_ID_EX = 1'b1;
              SQUASH_EX   = 1'b1;
            end
          end
        end
        DRAIN: begin
          HOLD_PC     = 1'b1;
          FLUSH_IF_ID = 1'b1;
          FLUSH_ID_EX = 1'b1;
          BUSY        = 1'b1;
        end
        TRAP: begin
          FLUSH_IF_ID = 1'b1;
          FLUSH_ID_EX = 1'b1;
          BUSY        = 1'b1;
          if (STALL) begin
            HOLD_PC = 1'b1;
          end else begin
            pc_sel    = PC_MTVEC;
            INT_TAKEN = 1'b1;
            MEPC_WE   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign PC_SEL = pc_sel;
  assign MEPC   = mepc_q;

endmodule

// File: tb/tb_otter_redirect_ctrl.sv
// Randomized and directed bench for otter_redirect_ctrl; a DRAIN_CYCLES=2 and a
// DRAIN_CYCLES=0 instance share stimulus and are each compared to a cycle-level model.
module tb_otter_redirect_ctrl;
  import otter_ctrl_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, stall, ex_valid, ex_is_mret, intr, mie;
  logic [2:0]      ex_src;
  logic [XLEN-1:0] ex_pc;

  logic [2:0]      pc_sel_d2, pc_sel_d0;
  logic            hold_d2, fif_d2, fidex_d2, sq_d2, it_d2, we_d2, busy_d2;
  logic            hold_d0, fif_d0, fidex_d0, sq_d0, it_d0, we_d0, busy_d0;
  logic [XLEN-1:0] mepc_d2, mepc_d0;

  otter_redirect_ctrl #(.DRAIN_CYCLES(2), .XLEN(XLEN)) dut_d2 (
    .CLK(clk), .RST(rst), .STALL(stall), .EX_VALID(ex_valid),
    .EX_PC_SOURCE(ex_src), .EX_IS_MRET(ex_is_mret), .EX_PC(ex_pc),
    .INTR(intr), .MIE(mie), .PC_SEL(pc_sel_d2), .HOLD_PC(hold_d2),
    .FLUSH_IF_ID(fif_d2), .FLUSH_ID_EX(fidex_d2), .SQUASH_EX(sq_d2),
    .INT_TAKEN(it_d2), .MEPC_WE(we_d2), .MEPC(mepc_d2), .BUSY(busy_d2)
  );

  otter_redirect_ctrl #(.DRAIN_CYCLES(0), .XLEN(XLEN)) dut_d0 (
    .CLK(clk), .RST(rst), .STALL(stall), .EX_VALID(ex_valid),
    .EX_PC_SOURCE(ex_src), .EX_IS_MRET(ex_is_mret), .EX_PC(ex_pc),
    .INTR(intr), .MIE(mie), .PC_SEL(pc_sel_d0), .HOLD_PC(hold_d0),
    .FLUSH_IF_ID(fif_d0), .FLUSH_ID_EX(fidex_d0), .SQUASH_EX(sq_d0),
    .INT_TAKEN(it_d0), .MEPC_WE(we_d0), .MEPC(mepc_d0), .BUSY(busy_d0)
  );

  int error_count = 0;
  int check_count = 0;
  int cycle_num   = 0;
  int it_pulses_d2 = 0;

  // Model: rem < 0 means idle; otherwise rem non-stalled edges remain before the trap cycle.
  int              rem[2]       = '{-1, -1};
  logic [XLEN-1:0] mepc_m[2]    = '{32'd0, 32'd0};
  int              drain_len[2] = '{2, 0};

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s cycle=%0d observed=0x%0h expected=0x%0h",
               tag, cycle_num, observed, expected);
    end
  endtask

  function automatic logic model_accept();
    logic [2:0] src;
    src = (ex_src > 3'd3) ? 3'd0 : ex_src;
    return ex_valid && intr && mie && !ex_is_mret && (src == 3'd0);
  endfunction

  // Packed as {pc_sel[2:0], hold, flush_if_id, flush_id_ex, squash, int_taken, mepc_we, busy}
  function automatic logic [9:0] model_out(input int i);
    logic [2:0] src;
    if (rst) return 10'd0;
    if (rem[i] > 0) return {3'd0, 7'b1110001};
    if (rem[i] == 0) return stall ? {3'd0, 7'b1110001} : {3'd4, 7'b0110111};
    if (stall || !ex_valid) return 10'd0;
    src = (ex_src > 3'd3) ? 3'd0 : ex_src;
    if (ex_is_mret)   return {3'd5, 7'b0110000};
    if (src != 3'd0)  return {src, 7'b0110000};
    if (intr && mie)  return {3'd0, 7'b1111000};
    return 10'd0;
  endfunction

  task automatic model_step(input int i);
    if (rst) begin
      rem[i]    = -1;
      mepc_m[i] = '0;
    end else if (rem[i] < 0) begin
      if (!stall && model_accept()) begin
        mepc_m[i] = ex_pc;
        rem[i]    = drain_len[i];
      end
    end else if (!stall) begin
      rem[i] = rem[i] - 1;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic v,
                               input logic [2:0] src, input logic m,
                               input logic [XLEN-1:0] pc, input logic irq,
                               input logic en);
    rst = r; stall = s; ex_valid = v; ex_src = src; ex_is_mret = m;
    ex_pc = pc; intr = irq; mie = en;
    @(negedge clk);
    checkOutput("outs_d2", 64'({pc_sel_d2, hold_d2, fif_d2, fidex_d2, sq_d2, it_d2, we_d2, busy_d2}),
                64'(model_out(0)));
    checkOutput("mepc_d2", 64'(mepc_d2), 64'(mepc_m[0]));
    checkOutput("outs_d0", 64'({pc_sel_d0, hold_d0, fif_d0, fidex_d0, sq_d0, it_d0, we_d0, busy_d0}),
                64'(model_out(1)));
    checkOutput("mepc_d0", 64'(mepc_d0), 64'(mepc_m[1]));
    if (it_d2) it_pulses_d2++;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    cycle_num++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 3'd0, 0, '0, 0, 0);
  endtask

  initial begin
    // Reset with a pending redirect and interrupt present
    applyStimulus(1, 0, 1, 3'd3, 0, 32'h0000_0040, 1, 1);
    applyStimulus(1, 0, 1, 3'd3, 0, 32'h0000_0040, 1, 1);
    applyStimulus(0, 0, 1, 3'd3, 0, 32'h0000_0040, 0, 0);
    idle(1);

    // Branch beats interrupt, then acceptance on the following instruction
    applyStimulus(0, 0, 1, 3'd2, 0, 32'h0000_0100, 1, 1);
    applyStimulus(0, 0, 1, 3'd0, 0, 32'h0000_0104, 1, 1);
    applyStimulus(0, 0, 1, 3'd1, 0, 32'h0000_0108, 0, 1);
    idle(4);
    checkOutput("pulses_seq1", 64'(it_pulses_d2), 64'd1);

    // Stall three cycles mid-drain and one cycle in trap
    applyStimulus(0, 0, 1, 3'd0, 0, 32'h0000_0200, 1, 1);
    applyStimulus(0, 1, 1, 3'd3, 0, 32'h0000_0300, 0, 1);
    applyStimulus(0, 1, 1, 3'd3, 0, 32'h0000_0300, 0, 1);
    applyStimulus(0, 1, 1, 3'd3, 0, 32'h0000_0300, 0, 1);
    applyStimulus(0, 0, 1, 3'd3, 1, 32'h0000_0300, 1, 1);
    applyStimulus(0, 0, 0, 3'd0, 0, 32'h0000_0300, 1, 1);
    applyStimulus(0, 1, 0, 3'd0, 0, 32'h0000_0300, 1, 1);
    applyStimulus(0, 0, 0, 3'd0, 0, 32'h0000_0300, 0, 0);
    idle(2);
    checkOutput("pulses_seq2", 64'(it_pulses_d2), 64'd2);

    // MRET precedence, masked interrupt, illegal source, stalled RUN
    applyStimulus(0, 0, 1, 3'd0, 1, 32'h0000_0400, 0, 0);
    applyStimulus(0, 0, 1, 3'd3, 1, 32'h0000_0404, 1, 1);
    applyStimulus(0, 0, 1, 3'd0, 0, 32'h0000_0408, 1, 0);
    applyStimulus(0, 0, 1, 3'd6, 0, 32'h0000_040c, 0, 1);
    applyStimulus(0, 1, 1, 3'd0, 0, 32'h0000_0410, 1, 1);
    applyStimulus(0, 0, 0, 3'd0, 0, 32'h0000_0414, 1, 1);
    idle(4);

    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 7) == 0),
                    {$urandom_range(0, 32'h3fff_ffff), 2'b00},
                    ($urandom_range(0, 1) == 0),
                    ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
